// File: rtl/id_stage.sv
// Decode stage: instruction FIFO feeding a single registered decode/issue slot with load-use interlock.
// Optional divide scoreboard enabled by defining ID_DIV_SCOREBOARD_EN.
module id_stage #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_valid_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    output logic        inst_ready_o,
    input  logic        flush_i,

    output logic [4:0]  reg1_raddr_o,
    output logic [4:0]  reg2_raddr_o,
    input  logic [31:0] reg1_rdata_i,
    input  logic [31:0] reg2_rdata_i,

    output logic        ex_valid_o,
    input  logic        ex_ready_i,

    output logic [31:0] op1_o,
    output logic [31:0] op2_o,
    output logic        reg_wen_o,
    output logic [4:0]  reg_w_addr_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic [31:0] reg1_rdata_o,
    output logic [31:0] reg2_rdata_o,
    output logic        mem_ren_o,
    output logic [31:0] mem_raddr_o,

    input  logic        div_done_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    logic [31:0]   fifo_inst [DEPTH];
    logic [31:0]   fifo_addr [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic push;
    logic pop;
    logic issue;
    logic stall;
    logic head_valid;

    logic [31:0] head_inst;
    logic [31:0] head_addr;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_j;
    logic [31:0] imm_u;

    logic        known;
    logic        rd_rs1;
    logic        rd_rs2;
    logic        writes_rd;
    logic        is_div;
    logic [31:0] d_op1;
    logic [31:0] d_op2;
    logic        d_mem_ren;
    logic [31:0] d_mem_raddr;
    logic        d_wen;
    logic [4:0]  d_waddr;

    assign inst_ready_o = (count != FULL_CNT);
    assign head_valid   = (count != '0);
    assign push         = inst_valid_i & inst_ready_o & ~flush_i;
    assign pop          = issue;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst[wr_ptr] <= inst_i;
            fifo_addr[wr_ptr] <= inst_addr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_inst = fifo_inst[rd_ptr];
    assign head_addr = fifo_addr[rd_ptr];
    assign opc   = head_inst[6:0];
    assign rd    = head_inst[11:7];
    assign f3    = head_inst[14:12];
    assign rs1   = head_inst[19:15];
    assign rs2   = head_inst[24:20];
    assign f7    = head_inst[31:25];
    assign imm_i = {{20{head_inst[31]}}, head_inst[31:20]};
    assign imm_j = {{11{head_inst[31]}}, head_inst[31], head_inst[19:12],
                    head_inst[20], head_inst[30:21], 1'b0};
    assign imm_u = {head_inst[31:12], 12'b0};

    // Unrecognised encodings leave everything at zero so they issue as bubbles.
    always_comb begin
        known       = 1'b0;
        rd_rs1      = 1'b0;
        rd_rs2      = 1'b0;
        writes_rd   = 1'b0;
        is_div      = 1'b0;
        d_op1       = '0;
        d_op2       = '0;
        d_mem_ren   = 1'b0;
        d_mem_raddr = '0;
        case (opc)
            OPC_OP_IMM: begin
                if (f3 == 3'b001) begin
                    known = (f7 == 7'b0000000);
                    d_op2 = {27'b0, rs2};
                end else if (f3 == 3'b101) begin
                    known = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                    d_op2 = {27'b0, rs2};
                end else begin
                    known = 1'b1;
                    d_op2 = imm_i;
                end
                if (known) begin
                    rd_rs1    = 1'b1;
                    writes_rd = 1'b1;
                    d_op1     = reg1_rdata_i;
                end else begin
                    d_op2 = '0;
                end
            end
            OPC_OP: begin
                if (f7 == 7'b0000001) begin
                    known  = 1'b1;
                    is_div = f3[2];
                end else begin
                    known = (f7 == 7'b0000000) ||
                            ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
                end
                if (known) begin
                    rd_rs1    = 1'b1;
                    rd_rs2    = 1'b1;
                    writes_rd = 1'b1;
                    d_op1     = reg1_rdata_i;
                    d_op2     = reg2_rdata_i;
                end
            end
            OPC_BRANCH, OPC_STORE: begin
                if (opc == OPC_BRANCH) known = (f3 != 3'b010) && (f3 != 3'b011);
                else                   known = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
                if (known) begin
                    rd_rs1 = 1'b1;
                    rd_rs2 = 1'b1;
                    d_op1  = reg1_rdata_i;
                    d_op2  = reg2_rdata_i;
                end
            end
            OPC_LOAD: begin
                known = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
                if (known) begin
                    rd_rs1      = 1'b1;
                    writes_rd   = 1'b1;
                    d_mem_ren   = 1'b1;
                    d_mem_raddr = reg1_rdata_i + imm_i;
                end
            end
            OPC_JAL: begin
                known     = 1'b1;
                writes_rd = 1'b1;
                d_op1     = imm_j;
            end
            OPC_JALR: begin
                known = (f3 == 3'b000);
                if (known) begin
                    rd_rs1    = 1'b1;
                    writes_rd = 1'b1;
                    d_op1     = reg1_rdata_i;
                    d_op2     = imm_i;
                end
            end
            OPC_LUI, OPC_AUIPC: begin
                known     = 1'b1;
                writes_rd = 1'b1;
                d_op1     = imm_u;
            end
            default: known = 1'b0;
        endcase
    end

    // Divide results come back through the divider, never through this write port.
    assign d_wen   = writes_rd & ~is_div & (rd != 5'd0);
    assign d_waddr = writes_rd ? rd : 5'd0;

    assign reg1_raddr_o = (head_valid & rd_rs1) ? rs1 : 5'd0;
    assign reg2_raddr_o = (head_valid & rd_rs2) ? rs2 : 5'd0;

    logic hazard_load;
    logic hazard_div;

    assign hazard_load = ex_valid_o & mem_ren_o & (reg_w_addr_o != 5'd0) &
                         ((rd_rs1 & (rs1 == reg_w_addr_o)) | (rd_rs2 & (rs2 == reg_w_addr_o)));

`ifdef ID_DIV_SCOREBOARD_EN
    logic       div_busy;
    logic [4:0] div_busy_addr;

    assign hazard_div = div_busy & ((rd_rs1 & (rs1 == div_busy_addr)) |
                                    (rd_rs2 & (rs2 == div_busy_addr)) |
                                    (writes_rd & (rd == div_busy_addr)) |
                                    is_div);

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_busy      <= 1'b0;
            div_busy_addr <= 5'd0;
        end else if (issue && is_div) begin
            div_busy      <= 1'b1;
            div_busy_addr <= rd;
        end else if (div_done_i && div_busy) begin
            div_busy <= 1'b0;
        end
    end
`else
    logic div_done_unused;
    assign div_done_unused = div_done_i;
    assign hazard_div      = 1'b0;
`endif

    assign stall = hazard_load | hazard_div;
    assign issue = head_valid & ~stall & (~ex_valid_o | ex_ready_i) & ~flush_i;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_valid_o   <= 1'b0;
            op1_o        <= '0;
            op2_o        <= '0;
            reg_wen_o    <= 1'b0;
            reg_w_addr_o <= '0;
            inst_o       <= '0;
            inst_addr_o  <= '0;
            reg1_rdata_o <= '0;
            reg2_rdata_o <= '0;
            mem_ren_o    <= 1'b0;
            mem_raddr_o  <= '0;
        end else if (flush_i) begin
            ex_valid_o <= 1'b0;
        end else if (issue) begin
            ex_valid_o   <= 1'b1;
            op1_o        <= d_op1;
            op2_o        <= d_op2;
            reg_wen_o    <= d_wen;
            reg_w_addr_o <= d_waddr;
            inst_o       <= head_inst;
            inst_addr_o  <= head_addr;
            reg1_rdata_o <= rd_rs1 ? reg1_rdata_i : 32'd0;
            reg2_rdata_o <= rd_rs2 ? reg2_rdata_i : 32'd0;
            mem_ren_o    <= d_mem_ren;
            mem_raddr_o  <= d_mem_raddr;
        end else if (ex_ready_i) begin
            ex_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode vector table plus load-use, full FIFO, divide, flush and reset sequences.
module tb_id_stage;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid_i;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic        inst_ready_o;
    logic        flush_i;
    logic [4:0]  reg1_raddr_o;
    logic [4:0]  reg2_raddr_o;
    logic [31:0] reg1_rdata_i;
    logic [31:0] reg2_rdata_i;
    logic        ex_valid_o;
    logic        ex_ready_i;
    logic [31:0] op1_o;
    logic [31:0] op2_o;
    logic        reg_wen_o;
    logic [4:0]  reg_w_addr_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic [31:0] reg1_rdata_o;
    logic [31:0] reg2_rdata_o;
    logic        mem_ren_o;
    logic [31:0] mem_raddr_o;
    logic        div_done_i;

    logic [31:0] regs [32];

    assign reg1_rdata_i = regs[reg1_raddr_o];
    assign reg2_rdata_i = regs[reg2_raddr_o];

    id_stage #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_valid_i (inst_valid_i),
        .inst_i       (inst_i),
        .inst_addr_i  (inst_addr_i),
        .inst_ready_o (inst_ready_o),
        .flush_i      (flush_i),
        .reg1_raddr_o (reg1_raddr_o),
        .reg2_raddr_o (reg2_raddr_o),
        .reg1_rdata_i (reg1_rdata_i),
        .reg2_rdata_i (reg2_rdata_i),
        .ex_valid_o   (ex_valid_o),
        .ex_ready_i   (ex_ready_i),
        .op1_o        (op1_o),
        .op2_o        (op2_o),
        .reg_wen_o    (reg_wen_o),
        .reg_w_addr_o (reg_w_addr_o),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .reg1_rdata_o (reg1_rdata_o),
        .reg2_rdata_o (reg2_rdata_o),
        .mem_ren_o    (mem_ren_o),
        .mem_raddr_o  (mem_raddr_o),
        .div_done_i   (div_done_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        wen;
        logic [4:0]  waddr;
        logic        wchk;
        logic        mren;
        logic [31:0] maddr;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] addi_k(input int k);
        logic [31:0] v;
        v = (32'(k) << 20) | (32'(k + 1) << 7) | 32'h13;
        return v;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_q [$];
        int          acc;
        int          got;

        for (int r = 0; r < 32; r++) regs[r] = 32'd0;
        regs[1]  = 32'h0000_0011;
        regs[2]  = 32'h0000_0100;
        regs[3]  = 32'h0000_0033;
        regs[5]  = 32'h0000_0055;
        regs[7]  = 32'h0000_0077;
        regs[10] = 32'hFFFF_FFF0;

        //           inst          ra1 ra2 op1           op2           wen waddr wchk mren maddr
        vecs[0]  = '{32'hFFB00093, 0,  0,  32'h0,        32'hFFFFFFFB, 1, 1, 1, 0, 32'h0};
        vecs[1]  = '{32'h00128333, 5,  1,  32'h55,       32'h11,       1, 6, 1, 0, 32'h0};
        vecs[2]  = '{32'h00812283, 2,  0,  32'h0,        32'h0,        1, 5, 1, 1, 32'h108};
        vecs[3]  = '{32'hFF052203, 10, 0,  32'h0,        32'h0,        1, 4, 1, 1, 32'hFFFFFFE0};
        vecs[4]  = '{32'h40455193, 10, 0,  32'hFFFFFFF0, 32'h4,        1, 3, 1, 0, 32'h0};
        vecs[5]  = '{32'h00208863, 1,  2,  32'h11,       32'h100,      0, 0, 0, 0, 32'h0};
        vecs[6]  = '{32'h0030A223, 1,  3,  32'h11,       32'h33,       0, 0, 0, 0, 32'h0};
        vecs[7]  = '{32'hFFDFF0EF, 0,  0,  32'hFFFFFFFC, 32'h0,        1, 1, 1, 0, 32'h0};
        vecs[8]  = '{32'h123453B7, 0,  0,  32'h12345000, 32'h0,        1, 7, 1, 0, 32'h0};
        vecs[9]  = '{32'hFFF38067, 7,  0,  32'h77,       32'hFFFFFFFF, 0, 0, 0, 0, 32'h0};
        vecs[10] = '{32'hFFFFFFFF, 0,  0,  32'h0,        32'h0,        0, 0, 1, 0, 32'h0};
        vecs[11] = '{32'h40209233, 0,  0,  32'h0,        32'h0,        0, 0, 1, 0, 32'h0};
        vecs[12] = '{32'h023084B3, 1,  3,  32'h11,       32'h33,       1, 9, 1, 0, 32'h0};
        vecs[13] = '{32'hFFFFF297, 0,  0,  32'hFFFFF000, 32'h0,        1, 5, 1, 0, 32'h0};
        vecs[14] = '{32'h01F09113, 1,  0,  32'h11,       32'h1F,       1, 2, 1, 0, 32'h0};

        rst          = 1'b0;
        inst_valid_i = 1'b0;
        inst_i       = 32'd0;
        inst_addr_i  = 32'd0;
        flush_i      = 1'b0;
        ex_ready_i   = 1'b1;
        div_done_i   = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        chk("reset ex_valid", 32'(ex_valid_o), 32'd0);
        chk("reset inst_ready", 32'(inst_ready_o), 32'd1);
        chk("reset op1", op1_o, 32'd0);
        chk("reset mem_raddr", mem_raddr_o, 32'd0);

        // Decode table: one instruction at a time through an idle stage.
        for (int i = 0; i < NVEC; i++) begin
            inst_valid_i = 1'b1;
            inst_i       = vecs[i].inst;
            inst_addr_i  = 32'h1000 + 32'(i * 4);
            tick();
            inst_valid_i = 1'b0;
            chk($sformatf("v%0d latency ex_valid", i), 32'(ex_valid_o), 32'd0);
            chk($sformatf("v%0d raddr1", i), 32'(reg1_raddr_o), 32'(vecs[i].ra1));
            chk($sformatf("v%0d raddr2", i), 32'(reg2_raddr_o), 32'(vecs[i].ra2));
            tick();
            chk($sformatf("v%0d ex_valid", i), 32'(ex_valid_o), 32'd1);
            chk($sformatf("v%0d inst", i), inst_o, vecs[i].inst);
            chk($sformatf("v%0d inst_addr", i), inst_addr_o, 32'h1000 + 32'(i * 4));
            chk($sformatf("v%0d op1", i), op1_o, vecs[i].op1);
            chk($sformatf("v%0d op2", i), op2_o, vecs[i].op2);
            chk($sformatf("v%0d wen", i), 32'(reg_wen_o), 32'(vecs[i].wen));
            if (vecs[i].wchk)
                chk($sformatf("v%0d waddr", i), 32'(reg_w_addr_o), 32'(vecs[i].waddr));
            chk($sformatf("v%0d mem_ren", i), 32'(mem_ren_o), 32'(vecs[i].mren));
            chk($sformatf("v%0d mem_raddr", i), mem_raddr_o, vecs[i].maddr);
            if (vecs[i].ra1 != 5'd0)
                chk($sformatf("v%0d rdata1", i), reg1_rdata_o, regs[vecs[i].ra1]);
            if (vecs[i].ra2 != 5'd0)
                chk($sformatf("v%0d rdata2", i), reg2_rdata_o, regs[vecs[i].ra2]);
            tick();
            chk($sformatf("v%0d drain ex_valid", i), 32'(ex_valid_o), 32'd0);
        end

        // Load-use: LW x5,8(x2) then ADD x6,x5,x1 takes exactly one bubble.
        inst_valid_i = 1'b1; inst_i = 32'h00812283; inst_addr_i = 32'h2000;
        tick();
        inst_i = 32'h00128333; inst_addr_i = 32'h2004;
        tick();
        inst_valid_i = 1'b0;
        chk("lu lw ex_valid", 32'(ex_valid_o), 32'd1);
        chk("lu lw inst", inst_o, 32'h00812283);
        chk("lu lw mem_raddr", mem_raddr_o, 32'h108);
        tick();
        chk("lu bubble ex_valid", 32'(ex_valid_o), 32'd0);
        tick();
        chk("lu add ex_valid", 32'(ex_valid_o), 32'd1);
        chk("lu add inst", inst_o, 32'h00128333);
        chk("lu add op1", op1_o, 32'h55);
        tick();

        // Full FIFO: one held in the output slot, then DEPTH accepts fill the queue.
        ex_ready_i   = 1'b0;
        inst_valid_i = 1'b1; inst_i = addi_k(0); inst_addr_i = 32'h3000;
        exp_q.push_back(addi_k(0));
        tick();
        inst_valid_i = 1'b0;
        tick();
        acc = 0;
        for (int k = 1; k <= DEPTH + 3; k++) begin
            if (!inst_ready_o) break;
            inst_valid_i = 1'b1; inst_i = addi_k(k); inst_addr_i = 32'h3000 + 32'(k * 4);
            exp_q.push_back(addi_k(k));
            tick();
            acc++;
        end
        inst_valid_i = 1'b0;
        chk("full accepts", 32'(acc), 32'(DEPTH));
        chk("full inst_ready", 32'(inst_ready_o), 32'd0);
        chk("full held inst", inst_o, addi_k(0));
        ex_ready_i = 1'b1;
        got = 0;
        for (int c = 0; c < 3 * DEPTH; c++) begin
            if (ex_valid_o) begin
                if (exp_q.size() != 0) chk($sformatf("full order %0d", got), inst_o, exp_q.pop_front());
                else                   chk($sformatf("full extra %0d", got), inst_o, 32'hFFFF_FFFF);
                got++;
            end
            tick();
        end
        chk("full drained count", 32'(got), 32'(DEPTH + 1));

        // Divide followed by dependent ADD x8,x7,x3.
        inst_valid_i = 1'b1; inst_i = 32'h0220C3B3; inst_addr_i = 32'h4000;
        tick();
        inst_i = 32'h00338433; inst_addr_i = 32'h4004;
        tick();
        inst_valid_i = 1'b0;
        chk("div inst", inst_o, 32'h0220C3B3);
        chk("div wen", 32'(reg_wen_o), 32'd0);
        chk("div waddr", 32'(reg_w_addr_o), 32'd7);
`ifdef ID_DIV_SCOREBOARD_EN
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("div hold %0d", c), 32'(ex_valid_o), 32'd0);
        end
        div_done_i = 1'b1;
        tick();
        div_done_i = 1'b0;
        chk("div done edge ex_valid", 32'(ex_valid_o), 32'd0);
        tick();
        chk("div dep ex_valid", 32'(ex_valid_o), 32'd1);
        chk("div dep inst", inst_o, 32'h00338433);
`else
        tick();
        chk("div dep ex_valid", 32'(ex_valid_o), 32'd1);
        chk("div dep inst", inst_o, 32'h00338433);
`endif
        tick();
        tick();

        // Flush with three queued and a concurrent push.
        ex_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            inst_valid_i = 1'b1; inst_i = addi_k(10 + k); inst_addr_i = 32'h5000 + 32'(k * 4);
            tick();
        end
        flush_i = 1'b1; inst_i = addi_k(20); inst_addr_i = 32'h5100;
        tick();
        flush_i = 1'b0; inst_valid_i = 1'b0;
        chk("flush ex_valid", 32'(ex_valid_o), 32'd0);
        chk("flush inst_ready", 32'(inst_ready_o), 32'd1);
        ex_ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("flush empty %0d", c), 32'(ex_valid_o), 32'd0);
        end

        // Reset while the ADD is held behind a load.
        ex_ready_i   = 1'b0;
        inst_valid_i = 1'b1; inst_i = 32'h00812283; inst_addr_i = 32'h6000;
        tick();
        inst_i = 32'h00128333; inst_addr_i = 32'h6004;
        tick();
        inst_valid_i = 1'b0;
        tick();
        chk("rst pre ex_valid", 32'(ex_valid_o), 32'd1);
        chk("rst pre mem_raddr", mem_raddr_o, 32'h108);
        rst = 1'b0;
        tick();
        chk("rst ex_valid", 32'(ex_valid_o), 32'd0);
        chk("rst mem_ren", 32'(mem_ren_o), 32'd0);
        chk("rst mem_raddr", mem_raddr_o, 32'd0);
        chk("rst waddr", 32'(reg_w_addr_o), 32'd0);
        chk("rst rdata1", reg1_rdata_o, 32'd0);
        chk("rst inst", inst_o, 32'd0);
        chk("rst inst_addr", inst_addr_o, 32'd0);
        chk("rst raddr1", 32'(reg1_raddr_o), 32'd0);
        rst = 1'b1;
        chk("rst inst_ready", 32'(inst_ready_o), 32'd1);
        ex_ready_i = 1'b1;
        tick();
        tick();
        chk("rst fifo empty", 32'(ex_valid_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 4, instruction FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports inst_valid_i input 1, inst_i input 32, inst_addr_i input 32: fetched instruction and its address.
REQ-005 SHALL have port inst_ready_o  output  1  FIFO can accept (not full).
REQ-006 SHALL have port flush_i  input  1  jump/branch taken, discard younger instructions.
REQ-007 SHALL have ports reg1_raddr_o, reg2_raddr_o  output  5  register-file read addresses for FIFO head.
REQ-008 SHALL have ports reg1_rdata_i, reg2_rdata_i  input  32  combinational register-file read data.
REQ-009 SHALL have ports ex_valid_o output 1, ex_ready_i input 1: decode-to-ex handshake.
REQ-010 SHALL have registered outputs op1_o 32, op2_o 32, reg_wen_o 1, reg_w_addr_o 5, inst_o 32, inst_addr_o 32, reg1_rdata_o 32, reg2_rdata_o 32, mem_ren_o 1, mem_raddr_o 32.
REQ-011 SHALL have port div_done_i  input  1  divider has written its result back.

Function
REQ-012 SHALL push inst_i/inst_addr_i on inst_valid_i & inst_ready_o & !flush_i; inst_ready_o = (count != DEPTH).
REQ-013 SHALL wrap read/write pointers modulo DEPTH; count width clog2(DEPTH)+1; push and pop in same cycle leave count unchanged.
REQ-014 SHALL drive reg1_raddr_o/reg2_raddr_o from head rs1/rs2 when the head type reads them, else 0; 0 when FIFO empty.
REQ-015 SHALL decode head: I-ALU op1=rs1 data, op2=sign-extended imm[31:20]; SLLI/SRLI/SRAI op2=zero-extended shamt; R and M op1/op2=rs1/rs2 data; B and S op1/op2=rs1/rs2 data, reg_wen 0.
REQ-016 SHALL decode load: mem_ren_o=1, mem_raddr_o=rs1 data + sign-extended imm (mod 2^32), op1=op2=0, reg_wen=1.
REQ-017 SHALL decode JAL op1=sign-extended J-immediate; JALR op1=rs1 data, op2=sign-extended imm; LUI/AUIPC op1={inst[31:12],12'b0}; op2=0 where unspecified.
REQ-018 SHALL issue unknown opcode/funct combinations with all data outputs 0 and reg_wen 0 (bubble that still carries inst_o/inst_addr_o).
REQ-019 SHALL force reg_wen_o=0 when rd=0.
REQ-020 SHALL load output register and pop head when head valid, no stall, and (!ex_valid_o | ex_ready_i); ex_valid_o then 1.
REQ-021 SHALL clear ex_valid_o when ex_ready_i=1 and nothing issues; SHALL hold all outputs stable while ex_valid_o & !ex_ready_i.
REQ-022 SHALL stall (load-use) when ex_valid_o & mem_ren_o & reg_w_addr_o!=0 and head reads that register via rs1 or rs2.
REQ-023 Minimum latency: instruction pushed at edge N appears with ex_valid_o=1 after edge N+1.
REQ-024 flush_i SHALL, at next edge, empty FIFO, clear ex_valid_o, ignore concurrent push; scoreboard unaffected.

Reset
REQ-025 rst=0 at a rising edge SHALL clear FIFO pointers/count, ex_valid_o, scoreboard busy, and all registered outputs to 0, including mid-stall or mid-divide.
REQ-026 inst_ready_o SHALL be 1 in the first cycle after reset release.

Configuration
REQ-027 Macro ID_DIV_SCOREBOARD_EN defined: issuing DIV/DIVU/REM/REMU sets busy=1, busy_addr=rd, with reg_wen_o=0; div_done_i clears busy next edge.
REQ-028 With ID_DIV_SCOREBOARD_EN: while busy, head SHALL stall if it reads or writes busy_addr or is any divide; div_done_i while not busy is ignored; div_done_i clears busy and a dependent head issues same edge +1.
REQ-029 Without ID_DIV_SCOREBOARD_EN: divides issue with reg_wen_o=0, no busy state, div_done_i ignored.

Verification
REQ-030 ADDI x1,x0,-5 (0xFFB00093) pushed, ex_ready_i=1 -> after 2 edges ex_valid_o=1, op2_o=0xFFFFFFFB, reg_w_addr_o=1, reg_wen_o=1.
REQ-031 LW x5,8(x2) with x2=0x100, then ADD x6,x5,x1 -> LW out with mem_raddr_o=0x108; ADD delayed exactly one bubble cycle.
REQ-032 Push DEPTH instructions with ex_ready_i=0 -> inst_ready_o=0 after DEPTH accepts; release ex_ready_i -> all emerge in order, no loss or duplicate.
REQ-033 Scoreboard: DIV x7,x1,x2 then ADD x8,x7,x3 -> ADD held until div_done_i pulse, issues next cycle; without macro, ADD issues immediately.
REQ-034 flush_i with 3 queued plus concurrent push -> next cycle ex_valid_o=0, FIFO empty, pushed instruction dropped.
REQ-035 rst=0 during load-use stall -> all outputs 0, inst_ready_o=1 after release.
